// File: rtl/cache_pkg.sv
// Shared definitions for the cache controller slice.
//   ADDR_DEF      : default word-address width
//   MEM_WIDTH_DEF : default data-word width
//   BLOCK_DEF     : default cache-line width (four words)
//   CNT_W_DEF     : default performance-counter width
//   state_e       : controller FSM states
package cache_pkg;

    localparam int ADDR_DEF      = 10;
    localparam int MEM_WIDTH_DEF = 32;
    localparam int BLOCK_DEF     = 128;
    localparam int CNT_W_DEF     = 16;

    typedef enum logic [2:0] {
        IDLE,
        RD_MISS,
        REFILL,
        RD_RESP,
        WR_MEM
    } state_e;

endpackage

// File: rtl/cache_ctrl_sat_counter.sv
// Saturating up-counter used for the hit/miss performance counters.
//   clk  : clock
//   rstn : synchronous active-low reset, clears the count
//   inc  : count-enable for this cycle
//   cnt  : current count, sticks at all-ones
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/cache_ctrl.sv
// Blocking cache controller: read-allocate, write-through, no-write-allocate.
//   clk, rstn                       : clock, synchronous active-low reset
//   cpu_req/we/addr/wdata           : CPU request, held until cpu_ready
//   cpu_rdata, cpu_ready            : load data and one-cycle completion pulse
//   c_wen/wtype/addr/wdata/wblock   : cache-array drive (wtype 1 = word, 0 = line fill)
//   c_rdata, c_hit                  : cache-array lookup result for c_addr
//   mem_req/we/addr/wdata           : main-memory request
//   mem_rblock, mem_ack             : memory response
//   hit_cnt, miss_cnt               : saturating performance counters
module cache_ctrl
    import cache_pkg::*;
#(
    parameter int ADDR      = ADDR_DEF,
    parameter int MEM_WIDTH = MEM_WIDTH_DEF,
    parameter int BLOCK     = BLOCK_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 cpu_req,
    input  logic                 cpu_we,
    input  logic [ADDR-1:0]      cpu_addr,
    input  logic [MEM_WIDTH-1:0] cpu_wdata,
    output logic [MEM_WIDTH-1:0] cpu_rdata,
    output logic                 cpu_ready,
    output logic                 c_wen,
    output logic                 c_wtype,
    output logic [ADDR-1:0]      c_addr,
    output logic [MEM_WIDTH-1:0] c_wdata,
    output logic [BLOCK-1:0]     c_wblock,
    input  logic [MEM_WIDTH-1:0] c_rdata,
    input  logic                 c_hit,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [ADDR-1:0]      mem_addr,
    output logic [MEM_WIDTH-1:0] mem_wdata,
    input  logic [BLOCK-1:0]     mem_rblock,
    input  logic                 mem_ack,
    output logic [CNT_W-1:0]     hit_cnt,
    output logic [CNT_W-1:0]     miss_cnt
);

    state_e                 state_q, state_d;
    logic [ADDR-1:0]        addr_q,  addr_d;
    logic [MEM_WIDTH-1:0]   wdata_q, wdata_d;
    logic                   hit_q,   hit_d;
    logic [BLOCK-1:0]       block_q, block_d;
    logic                   hit_inc, miss_inc;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            hit_q   <= 1'b0;
            block_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            hit_q   <= hit_d;
            block_q <= block_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        hit_d     = hit_q;
        block_d   = block_q;
        hit_inc   = 1'b0;
        miss_inc  = 1'b0;
        cpu_rdata = '0;
        cpu_ready = 1'b0;
        c_wen     = 1'b0;
        c_wtype   = 1'b0;
        c_addr    = addr_q;
        c_wdata   = '0;
        c_wblock  = '0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;

        unique case (state_q)
            IDLE: begin
                c_addr = cpu_addr;
                // Acceptance is gated by rstn so nothing pulses during the reset cycle.
                if (rstn && cpu_req) begin
                    if (cpu_we) begin
                        addr_d   = cpu_addr;
                        wdata_d  = cpu_wdata;
                        hit_d    = c_hit;
                        hit_inc  = c_hit;
                        miss_inc = !c_hit;
                        state_d  = WR_MEM;
                    end else if (c_hit) begin
                        cpu_ready = 1'b1;
                        cpu_rdata = c_rdata;
                        hit_inc   = 1'b1;
                    end else begin
                        addr_d   = cpu_addr;
                        miss_inc = 1'b1;
                        state_d  = RD_MISS;
                    end
                end
            end
            RD_MISS: begin
                mem_req  = 1'b1;
                mem_addr = {addr_q[ADDR-1:2], 2'b00};
                if (mem_ack) begin
                    block_d = mem_rblock;
                    state_d = REFILL;
                end
            end
            REFILL: begin
                c_wen    = 1'b1;
                c_wblock = block_q;
                state_d  = RD_RESP;
            end
            RD_RESP: begin
                cpu_ready = 1'b1;
                cpu_rdata = block_q[addr_q[1:0]*MEM_WIDTH +: MEM_WIDTH];
                state_d   = IDLE;
            end
            WR_MEM: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
                if (mem_ack) begin
                    cpu_ready = 1'b1;
                    if (hit_q) begin
                        c_wen   = 1'b1;
                        c_wtype = 1'b1;
                        c_wdata = wdata_q;
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    sat_counter #(.CNT_W(CNT_W)) u_hit_cnt (
        .clk  (clk),
        .rstn (rstn),
        .inc  (hit_inc),
        .cnt  (hit_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_miss_cnt (
        .clk  (clk),
        .rstn (rstn),
        .inc  (miss_inc),
        .cnt  (miss_cnt)
    );

endmodule

// File: tb/tb_cache_ctrl.sv
module tb_cache_ctrl;

    localparam int TCW = 4;

    logic         clk = 1'b0;
    logic         rstn;
    logic         cpu_req, cpu_we;
    logic [9:0]   cpu_addr;
    logic [31:0]  cpu_wdata, cpu_rdata;
    logic         cpu_ready;
    logic         c_wen, c_wtype;
    logic [9:0]   c_addr;
    logic [31:0]  c_wdata, c_rdata;
    logic [127:0] c_wblock;
    logic         c_hit;
    logic         mem_req, mem_we;
    logic [9:0]   mem_addr;
    logic [31:0]  mem_wdata;
    logic [127:0] mem_rblock;
    logic         mem_ack;
    logic [TCW-1:0] hit_cnt, miss_cnt;

    int nvec  = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    cache_ctrl #(.CNT_W(TCW)) dut (
        .clk(clk), .rstn(rstn),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
        .c_wen(c_wen), .c_wtype(c_wtype), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_wblock(c_wblock), .c_rdata(c_rdata), .c_hit(c_hit),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rblock(mem_rblock), .mem_ack(mem_ack),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    // Environment: cache array (one line per address[9:2]) and main memory.
    logic         cv [256];
    logic [31:0]  cd [1024];
    logic [31:0]  mem [1024];
    int           mem_lat = 2;
    logic         stray_ack = 1'b0;
    int           mcnt = 0;

    assign c_hit   = cv[c_addr[9:2]];
    assign c_rdata = cd[c_addr];
    assign mem_ack = (mem_req && (mcnt == mem_lat - 1)) || stray_ack;

    always_comb begin
        mem_rblock = {mem[{mem_addr[9:2], 2'd3}], mem[{mem_addr[9:2], 2'd2}],
                      mem[{mem_addr[9:2], 2'd1}], mem[{mem_addr[9:2], 2'd0}]};
    end

    always @(posedge clk) begin
        if (!mem_req || mem_ack) mcnt <= 0;
        else                     mcnt <= mcnt + 1;
        if (mem_req && mem_ack && mem_we) mem[mem_addr] <= mem_wdata;
        if (c_wen) begin
            if (c_wtype) begin
                cd[c_addr] <= c_wdata;
            end else begin
                for (int k = 0; k < 4; k++) cd[{c_addr[9:2], 2'(k)}] <= c_wblock[k*32 +: 32];
                cv[c_addr[9:2]] <= 1'b1;
            end
        end
    end

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction-level reference model, evaluated every cycle on the falling edge.
    logic         t_act = 1'b0, t_we = 1'b0, t_hit = 1'b0;
    logic [9:0]   t_addr = '0;
    logic [31:0]  t_wd = '0;
    int           t_ph = 0;
    logic [127:0] t_blk = '0;
    int           hc = 0, mc = 0;

    always @(negedge clk) begin
        logic [31:0]  e_rdata, e_cwd, e_mwd;
        logic [127:0] e_blk;
        logic [9:0]   e_caddr, e_maddr;
        logic         e_ready, e_cwen, e_wtype, e_mreq, e_mwe;
        e_rdata = '0; e_cwd = '0; e_mwd = '0; e_blk = '0; e_maddr = '0;
        e_ready = 0; e_cwen = 0; e_wtype = 0; e_mreq = 0; e_mwe = 0;
        e_caddr = t_act ? t_addr : cpu_addr;
        if (!t_act) begin
            if (rstn && cpu_req && !cpu_we && cv[cpu_addr[9:2]]) begin
                e_ready = 1; e_rdata = cd[cpu_addr];
            end
        end else if (!t_we) begin
            if (t_ph == 0) begin
                e_mreq = 1; e_maddr = {t_addr[9:2], 2'b00};
            end else if (t_ph == 1) begin
                e_cwen = 1; e_blk = t_blk;
            end else begin
                e_ready = 1; e_rdata = t_blk[t_addr[1:0]*32 +: 32];
            end
        end else begin
            e_mreq = 1; e_mwe = 1; e_maddr = t_addr; e_mwd = t_wd;
            if (mem_ack) begin
                e_ready = 1;
                if (t_hit) begin e_cwen = 1; e_wtype = 1; e_cwd = t_wd; end
            end
        end
        check("cpu_ready", cpu_ready, e_ready);
        check("cpu_rdata", cpu_rdata, e_rdata);
        check("c_wen",     c_wen,     e_cwen);
        check("c_wtype",   c_wtype,   e_wtype);
        check("c_addr",    c_addr,    e_caddr);
        check("c_wdata",   c_wdata,   e_cwd);
        check("c_wblock",  c_wblock,  e_blk);
        check("mem_req",   mem_req,   e_mreq);
        check("mem_we",    mem_we,    e_mwe);
        check("mem_addr",  mem_addr,  e_maddr);
        check("mem_wdata", mem_wdata, e_mwd);
        check("hit_cnt",   hit_cnt,   hc);
        check("miss_cnt",  miss_cnt,  mc);
        // Advance to the state expected after the coming rising edge.
        if (!rstn) begin
            t_act = 0; hc = 0; mc = 0;
        end else if (!t_act) begin
            if (cpu_req) begin
                if (cpu_we) begin
                    t_act = 1; t_we = 1; t_addr = cpu_addr; t_wd = cpu_wdata;
                    t_hit = cv[cpu_addr[9:2]];
                    if (t_hit) begin if (hc < 2**TCW - 1) hc++; end
                    else       begin if (mc < 2**TCW - 1) mc++; end
                end else if (cv[cpu_addr[9:2]]) begin
                    if (hc < 2**TCW - 1) hc++;
                end else begin
                    t_act = 1; t_we = 0; t_addr = cpu_addr; t_ph = 0;
                    if (mc < 2**TCW - 1) mc++;
                end
            end
        end else if (!t_we) begin
            if (t_ph == 0) begin
                if (mem_ack) begin
                    t_blk = {mem[{t_addr[9:2], 2'd3}], mem[{t_addr[9:2], 2'd2}],
                             mem[{t_addr[9:2], 2'd1}], mem[{t_addr[9:2], 2'd0}]};
                    t_ph = 1;
                end
            end else if (t_ph == 1) t_ph = 2;
            else t_act = 0;
        end else if (mem_ack) begin
            t_act = 0;
        end
    end

    logic [9:0] seen_maddr;
    logic       seen_fill, seen_wordwr;

    // Issue one request from posedge+1; returns load data and cycles to cpu_ready.
    task automatic req(input logic we, input logic [9:0] a, input logic [31:0] d,
                       input int lat, output logic [31:0] rd, output int cyc);
        logic got;
        got = 0; rd = '0; cyc = 0;
        seen_maddr = '0; seen_fill = 0; seen_wordwr = 0;
        mem_lat = lat;
        cpu_req = 1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            cyc++;
            if (mem_req) seen_maddr = mem_addr;
            if (c_wen) begin
                if (c_wtype) seen_wordwr = 1;
                else         seen_fill = 1;
            end
            if (cpu_ready) begin
                rd = cpu_rdata; got = 1;
                break;
            end
        end
        check("req_completed", got, 1'b1);
        @(posedge clk); #1;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    endtask

    initial begin
        logic [31:0] rd;
        int cyc;
        for (int i = 0; i < 1024; i++) begin
            mem[i] = 32'hA000_0000 + i;
            cd[i]  = '0;
        end
        for (int i = 0; i < 256; i++) cv[i] = 1'b0;
        cv[1] = 1'b1;
        for (int i = 4; i < 8; i++) cd[i] = 32'h1111_0000 + i;

        rstn = 0; cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", cpu_ready, 1'b0);
        check("rst_memreq", mem_req, 1'b0);
        check("rst_hitcnt", hit_cnt, 0);
        @(posedge clk); #1;
        rstn = 1;

        // Read hit
        req(0, 10'h004, '0, 2, rd, cyc);
        check("hit_data", rd, 32'h1111_0004);
        check("hit_latency", cyc, 1);
        @(negedge clk);
        check("hit_cnt_1", hit_cnt, 1);
        @(posedge clk); #1;

        // Read miss, latency 3
        req(0, 10'h00E, '0, 3, rd, cyc);
        check("miss_data", rd, 32'hA000_000E);
        check("miss_mem_addr", seen_maddr, 10'h00C);
        check("miss_fill", seen_fill, 1'b1);
        check("miss_latency", cyc, 6);
        @(negedge clk);
        check("miss_cnt_1", miss_cnt, 1);
        @(posedge clk); #1;

        // Write hit, latency 2, then reread
        req(1, 10'h005, 32'hDEAD_BEEF, 2, rd, cyc);
        check("wrhit_latency", cyc, 3);
        check("wrhit_cache_write", seen_wordwr, 1'b1);
        check("wrhit_mem", mem[5], 32'hDEAD_BEEF);
        req(0, 10'h005, '0, 2, rd, cyc);
        check("reread_data", rd, 32'hDEAD_BEEF);
        check("reread_latency", cyc, 1);

        // Write miss, then read of the same word misses
        req(1, 10'h100, 32'hCAFE_0100, 2, rd, cyc);
        check("wrmiss_no_word_wr", seen_wordwr, 1'b0);
        check("wrmiss_no_fill", seen_fill, 1'b0);
        check("wrmiss_mem", mem[10'h100], 32'hCAFE_0100);
        req(0, 10'h100, '0, 2, rd, cyc);
        check("rdmiss_latency", cyc, 5);
        check("rdmiss_data", rd, 32'hCAFE_0100);
        @(negedge clk);
        check("hit_cnt_3", hit_cnt, 3);
        check("miss_cnt_3", miss_cnt, 3);
        @(posedge clk); #1;

        // Reset in the middle of a read miss
        mem_lat = 10;
        cpu_req = 1; cpu_we = 0; cpu_addr = 10'h200;
        repeat (3) @(posedge clk);
        #1;
        cpu_req = 0; cpu_addr = '0; rstn = 0;
        @(negedge clk);
        check("pre_rst_memreq", mem_req, 1'b1);
        @(posedge clk); #1;
        rstn = 1; stray_ack = 1;
        @(negedge clk);
        check("post_rst_memreq", mem_req, 1'b0);
        check("post_rst_ready", cpu_ready, 1'b0);
        check("post_rst_miss", miss_cnt, 0);
        check("post_rst_hit", hit_cnt, 0);
        @(posedge clk); #1;
        stray_ack = 0;
        repeat (2) @(posedge clk);
        #1;

        // Back-to-back read hits saturate the counter
        cpu_req = 1; cpu_we = 0; cpu_addr = 10'h004;
        repeat (20) @(posedge clk);
        #1;
        cpu_req = 0; cpu_addr = '0;
        @(negedge clk);
        check("hit_cnt_sat", hit_cnt, 15);
        check("miss_cnt_zero", miss_cnt, 0);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
